integer_unit: RTL and testbench

//  Executes IU-class instructions (eu == EU_IU) for one warp per cycle, all WarpWidth lanes in parallel.

---
 rtl/integer_unit.sv | 147 ++++++++++++++
 tb/tb_integer_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_unit.sv
// Integer execution unit: evaluates one IU instruction across all warp lanes in one cycle
// and holds results in a 2-entry output FIFO toward the writeback arbiter.
module integer_unit #(
  parameter int unsigned WarpWidth    = 4,
  parameter int unsigned RegWidth     = 32,
  parameter int unsigned NumWarps     = 8,
  parameter int unsigned RegIdxWidth  = 8,
  parameter int unsigned BlockIdWidth = 8,
  localparam int unsigned WidWidth    = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int unsigned ImmWidth    = 2 * RegIdxWidth
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            opc_valid_i,
  output logic                            opc_ready_o,
  input  logic [5:0]                      opc_inst_i,
  input  logic [WarpWidth-1:0]            opc_act_mask_i,
  input  logic [WidWidth-1:0]             opc_warp_id_i,
  input  logic [BlockIdWidth-1:0]         opc_block_id_i,
  input  logic [RegWidth-1:0]             opc_dp_addr_i,
  input  logic [RegIdxWidth-1:0]          opc_dst_i,
  input  logic [ImmWidth-1:0]             opc_imm_i,
  input  logic [WarpWidth*RegWidth-1:0]   opc_a_i,
  input  logic [WarpWidth*RegWidth-1:0]   opc_b_i,
  output logic                            eu_valid_o,
  input  logic                            eu_ready_i,
  output logic [WarpWidth-1:0]            eu_act_mask_o,
  output logic [WidWidth-1:0]             eu_warp_id_o,
  output logic [RegIdxWidth-1:0]          eu_dst_o,
  output logic [WarpWidth*RegWidth-1:0]   eu_data_o,
  output logic                            err_illegal_o
);

  localparam int unsigned ShWidth    = $clog2(RegWidth);
  localparam int unsigned DataWidth  = WarpWidth * RegWidth;
  localparam int unsigned EntryWidth = WarpWidth + WidWidth + RegIdxWidth + DataWidth;

  localparam logic [5:0] IU_TID  = 6'd0;
  localparam logic [5:0] IU_WID  = 6'd1;
  localparam logic [5:0] IU_BID  = 6'd2;
  localparam logic [5:0] IU_TBID = 6'd3;
  localparam logic [5:0] IU_DPA  = 6'd4;
  localparam logic [5:0] IU_ADD  = 6'd5;
  localparam logic [5:0] IU_SUB  = 6'd6;
  localparam logic [5:0] IU_AND  = 6'd7;
  localparam logic [5:0] IU_OR   = 6'd8;
  localparam logic [5:0] IU_XOR  = 6'd9;
  localparam logic [5:0] IU_SLL  = 6'd10;
  localparam logic [5:0] IU_LDI  = 6'd11;
  localparam logic [5:0] IU_ADDI = 6'd12;
  localparam logic [5:0] IU_SUBI = 6'd13;
  localparam logic [5:0] IU_SLLI = 6'd14;

  // Handshake: a transfer happens on a rising edge where valid && ready; once valid is
  // raised the payload is held until that edge. opc_ready_o depends only on registered count.
  logic                  push, pop, illegal;
  logic [DataWidth-1:0]  lane_res;
  logic [RegWidth-1:0]   imm_ext;

  assign imm_ext = RegWidth'(opc_imm_i);
  assign illegal = (opc_inst_i > IU_SLLI);

  for (genvar gi = 0; gi < WarpWidth; gi++) begin : g_lane
    localparam logic [RegWidth-1:0] LaneIdx = RegWidth'(gi);
    logic [RegWidth-1:0] a, b, r;

    assign a = opc_a_i[gi*RegWidth +: RegWidth];
    assign b = opc_b_i[gi*RegWidth +: RegWidth];

    always_comb begin
      r = '0;
      case (opc_inst_i)
        IU_TID:  r = LaneIdx;
        IU_WID:  r = RegWidth'(opc_warp_id_i);
        IU_BID:  r = RegWidth'(opc_block_id_i);
        IU_TBID: r = RegWidth'(opc_block_id_i) * RegWidth'(WarpWidth) + LaneIdx;
        IU_DPA:  r = opc_dp_addr_i;
        IU_ADD:  r = a + b;
        IU_SUB:  r = a - b;
        IU_AND:  r = a & b;
        IU_OR:   r = a | b;
        IU_XOR:  r = a ^ b;
        IU_SLL:  r = a << b[ShWidth-1:0];
        IU_LDI:  r = imm_ext;
        IU_ADDI: r = a + imm_ext;
        IU_SUBI: r = a - imm_ext;
        IU_SLLI: r = a << imm_ext[ShWidth-1:0];
        default: r = '0;
      endcase
    end

    assign lane_res[gi*RegWidth +: RegWidth] = opc_act_mask_i[gi] ? r : '0;
  end

  logic [EntryWidth-1:0] mem_q [2];
  logic [EntryWidth-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  err_q, err_d;
  logic [EntryWidth-1:0] head;

  assign opc_ready_o = (count_q != 2'd2);
  assign eu_valid_o  = (count_q != 2'd0);
  assign push        = opc_valid_i && opc_ready_o;
  assign pop         = eu_valid_o && eu_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (push & illegal);
    if (push) begin
      mem_d[wr_ptr_q] = {opc_act_mask_i, opc_warp_id_i, opc_dst_i, lane_res};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Outputs read as zero whenever nothing is buffered, so stale slots never leak.
  assign head = eu_valid_o ? mem_q[rd_ptr_q] : '0;
  assign {eu_act_mask_o, eu_warp_id_o, eu_dst_o, eu_data_o} = head;
  assign err_illegal_o = err_q;

endmodule

// File: tb/tb_integer_unit.sv
// Directed and streamed stimulus for integer_unit; an expected-entry queue is filled at
// acceptance and drained by an independent output monitor.
module tb_integer_unit;
  localparam int W = 4, RW = 32, DW = 128, EW = 4 + 3 + 8 + 128;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          opc_valid_i = 1'b0, opc_ready_o;
  logic [5:0]    opc_inst_i = '0;
  logic [W-1:0]  opc_act_mask_i = '0;
  logic [2:0]    opc_warp_id_i = '0;
  logic [7:0]    opc_block_id_i = '0;
  logic [31:0]   opc_dp_addr_i = '0;
  logic [7:0]    opc_dst_i = '0;
  logic [15:0]   opc_imm_i = '0;
  logic [DW-1:0] opc_a_i = '0, opc_b_i = '0;
  logic          eu_valid_o, eu_ready_i = 1'b1;
  logic [W-1:0]  eu_act_mask_o;
  logic [2:0]    eu_warp_id_o;
  logic [7:0]    eu_dst_o;
  logic [DW-1:0] eu_data_o;
  logic          err_illegal_o;

  integer_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .opc_valid_i(opc_valid_i), .opc_ready_o(opc_ready_o), .opc_inst_i(opc_inst_i),
    .opc_act_mask_i(opc_act_mask_i), .opc_warp_id_i(opc_warp_id_i),
    .opc_block_id_i(opc_block_id_i), .opc_dp_addr_i(opc_dp_addr_i), .opc_dst_i(opc_dst_i),
    .opc_imm_i(opc_imm_i), .opc_a_i(opc_a_i), .opc_b_i(opc_b_i),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_act_mask_o(eu_act_mask_o),
    .eu_warp_id_o(eu_warp_id_o), .eu_dst_o(eu_dst_o), .eu_data_o(eu_data_o),
    .err_illegal_o(err_illegal_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0, stalls = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pk(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // reference model used for streamed vectors
  function automatic logic [DW-1:0] model(input logic [5:0] op, input logic [3:0] mask,
      input logic [2:0] wid, input logic [7:0] bid, input logic [31:0] dpa,
      input logic [15:0] imm, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    logic [31:0] x, y, r, im;
    d  = '0;
    im = {16'h0, imm};
    for (int i = 0; i < W; i++) begin
      x = a[i*RW +: RW];
      y = b[i*RW +: RW];
      case (op)
        6'd0:  r = i;
        6'd1:  r = {29'h0, wid};
        6'd2:  r = {24'h0, bid};
        6'd3:  r = bid * 4 + i;
        6'd4:  r = dpa;
        6'd5:  r = x + y;
        6'd6:  r = x - y;
        6'd7:  r = x & y;
        6'd8:  r = x | y;
        6'd9:  r = x ^ y;
        6'd10: r = x << (y % 32);
        6'd11: r = im;
        6'd12: r = x + im;
        6'd13: r = x - im;
        6'd14: r = x << (im % 32);
        default: r = 32'h0;
      endcase
      d[i*RW +: RW] = mask[i] ? r : 32'h0;
    end
    return d;
  endfunction

  // driver: holds the instruction until accepted, recording the expected entry on acceptance
  task automatic send(input logic [5:0] op, input logic [3:0] mask, input logic [2:0] wid,
      input logic [7:0] bid, input logic [31:0] dpa, input logic [7:0] dst,
      input logic [15:0] imm, input logic [DW-1:0] a, input logic [DW-1:0] b,
      input logic [DW-1:0] exp_data);
    logic acc;
    acc = 1'b0;
    opc_inst_i = op; opc_act_mask_i = mask; opc_warp_id_i = wid; opc_block_id_i = bid;
    opc_dp_addr_i = dpa; opc_dst_i = dst; opc_imm_i = imm; opc_a_i = a; opc_b_i = b;
    opc_valid_i = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_i);
      acc = opc_ready_o;
      if (acc) exp_q.push_back({mask, wid, dst, exp_data});
      @(posedge clk_i);
      #1;
      if (acc) break;
      stalls++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: op %h never accepted", op);
    end
    opc_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk_i);
    #1;
    check("drain_empty", EW'(exp_q.size()), '0);
  endtask

  // monitor: compares the head of the expectation queue whenever a result is presented
  always @(negedge clk_i) begin
    if (rst_ni && eu_valid_o) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_beat: got data %h, expected no beat", eu_data_o);
      end else begin
        check("beat", {eu_act_mask_o, eu_warp_id_o, eu_dst_o, eu_data_o}, exp_q[0]);
        if (eu_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [3:0] mask;
    logic [2:0] wid;
    logic [7:0] bid, dst;
    logic [31:0] dpa;
    logic [15:0] imm;
    logic [DW-1:0] a, b;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", EW'(eu_valid_o), EW'(1'b0));
    check("rst_ready", EW'(opc_ready_o), EW'(1'b1));
    check("rst_outs", {eu_act_mask_o, eu_warp_id_o, eu_dst_o, eu_data_o}, '0);
    check("rst_err", EW'(err_illegal_o), EW'(1'b0));
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 1: ADD and one-cycle latency
    send(6'd5, 4'hF, 3'd2, 8'd0, 32'h0, 8'd5, 16'h0, pk(1, 2, 3, 4), pk(10, 20, 30, 40),
         pk(11, 22, 33, 44));
    check("latency_valid", EW'(eu_valid_o), EW'(1'b1));
    drain();
    // 2: TBID with sparse mask
    send(6'd3, 4'b0101, 3'd1, 8'd3, 32'h0, 8'd9, 16'h0, '0, '0, pk(12, 0, 14, 0));
    // 3: SUBI wraparound and SLL shift-amount truncation
    send(6'd13, 4'hF, 3'd0, 8'd0, 32'h0, 8'd1, 16'd1, '0, '0,
         pk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    send(6'd10, 4'hF, 3'd0, 8'd0, 32'h0, 8'd2, 16'h0, pk(1, 1, 1, 1), pk(33, 33, 33, 33),
         pk(2, 2, 2, 2));
    // remaining subtypes
    send(6'd0, 4'hF, 3'd7, 8'd0, 32'h0, 8'd3, 16'h0, '0, '0, pk(0, 1, 2, 3));
    send(6'd1, 4'b1110, 3'd6, 8'd0, 32'h0, 8'd4, 16'h0, '0, '0, pk(0, 6, 6, 6));
    send(6'd2, 4'hF, 3'd0, 8'd200, 32'h0, 8'd4, 16'h0, '0, '0, pk(200, 200, 200, 200));
    send(6'd4, 4'b1001, 3'd0, 8'd0, 32'h1000, 8'd6, 16'h0, '0, '0, pk(32'h1000, 0, 0, 32'h1000));
    send(6'd11, 4'hF, 3'd0, 8'd0, 32'h0, 8'd7, 16'hABCD, '0, '0,
         pk(32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD));
    send(6'd14, 4'hF, 3'd0, 8'd0, 32'h0, 8'd8, 16'h0024, pk(3, 1, 32'h8000_0001, 0), '0,
         pk(32'h30, 32'h10, 32'h10, 0));
    send(6'd6, 4'hF, 3'd0, 8'd0, 32'h0, 8'd8, 16'h0, pk(5, 0, 100, 7), pk(3, 1, 1, 7),
         pk(2, 32'hFFFF_FFFF, 99, 0));
    send(6'd9, 4'hF, 3'd0, 8'd0, 32'h0, 8'd8, 16'h0, pk(32'hF0F0, 32'hFF, 0, 1),
         pk(32'h0FF0, 32'hF, 0, 1), pk(32'hFF00, 32'hF0, 0, 0));
    send(6'd12, 4'hF, 3'd0, 8'd0, 32'h0, 8'd8, 16'hFFFF, pk(1, 32'hFFFF_0001, 0, 2), '0,
         pk(32'h10000, 32'h0, 32'hFFFF, 32'h10001));
    drain();

    // 4: backpressure fills the buffer, then releases in order
    eu_ready_i = 1'b0;
    send(6'd7, 4'hF, 3'd1, 8'd0, 32'h0, 8'd10, 16'h0, pk(32'hFF, 32'hF0, 3, 0),
         pk(32'h0F, 32'hFF, 6, 5), pk(32'h0F, 32'hF0, 2, 0));
    send(6'd8, 4'hF, 3'd2, 8'd0, 32'h0, 8'd11, 16'h0, pk(32'hF0, 1, 0, 8), pk(32'h0F, 2, 0, 8),
         pk(32'hFF, 3, 0, 8));
    @(negedge clk_i);
    check("full_ready_low", EW'(opc_ready_o), EW'(1'b0));
    fork
      send(6'd5, 4'hF, 3'd3, 8'd0, 32'h0, 8'd12, 16'h0, pk(1, 1, 1, 1), pk(1, 2, 3, 4),
           pk(2, 3, 4, 5));
      begin
        repeat (3) @(posedge clk_i);
        #1 eu_ready_i = 1'b1;
      end
    join
    drain();

    // 5: 100 streamed ops at full rate
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      op = 6'($urandom_range(0, 15));
      mask = 4'($urandom_range(0, 15));
      wid = 3'($urandom_range(0, 7));
      bid = 8'($urandom_range(0, 255));
      dpa = $urandom; dst = 8'($urandom_range(0, 255)); imm = 16'($urandom_range(0, 65535));
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      send(op, mask, wid, bid, dpa, dst, imm, a, b, model(op, mask, wid, bid, dpa, imm, a, b));
    end
    check("stream_stalls", EW'(stalls), '0);
    drain();

    // 6: illegal subtype, then reset with a full buffer
    send(6'h3F, 4'hF, 3'd4, 8'd0, 32'h0, 8'd13, 16'h1234, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0);
    drain();
    check("err_sticky", EW'(err_illegal_o), EW'(1'b1));
    eu_ready_i = 1'b0;
    send(6'd11, 4'hF, 3'd0, 8'd0, 32'h0, 8'd1, 16'h1, '0, '0, pk(1, 1, 1, 1));
    send(6'd11, 4'hF, 3'd0, 8'd0, 32'h0, 8'd2, 16'h2, '0, '0, pk(2, 2, 2, 2));
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", EW'(eu_valid_o), EW'(1'b0));
    check("midrst_err", EW'(err_illegal_o), EW'(1'b0));
    check("midrst_data", EW'(eu_data_o), '0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    eu_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("post_rst_ready", EW'(opc_ready_o), EW'(1'b1));
    check("post_rst_valid", EW'(eu_valid_o), EW'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
